// File: rtl/mem_stage_pkg.sv
// Shared types for the uRISC pipeline back end: memory-stage FSM encoding
// and the writeback record passed from MEM to WB.
package uRISC_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  err;
    } wb_rec_t;

    function automatic wb_rec_t make_wb(
        input logic [DATA_W-1:0]     data,
        input logic [REG_ADDR_W-1:0] dest,
        input logic                  reg_write,
        input logic                  err
    );
        wb_rec_t rec;
        rec.valid     = 1'b1;
        rec.data      = data;
        rec.dest      = dest;
        rec.reg_write = reg_write;
        rec.err       = err;
        return rec;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/gnt/rvalid bus. master = memory stage, slave = memory.
interface mem_stage_if;
    import uRISC_pkg::*;

    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: turns EX/MEM results into data-memory accesses and
// emits one registered writeback record per accepted instruction.
module mem_stage
    import uRISC_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_exmm,
    input  logic [DATA_W-1:0]     alu_result_exmm,
    input  logic [DATA_W-1:0]     store_data_exmm,
    input  logic                  load_exmm,
    input  logic                  store_exmm,
    input  logic [REG_ADDR_W-1:0] dest_reg_exmm,
    input  logic                  reg_write_valid_exmm,
    mem_stage_if.master           dmem,
    output logic                  mem_stall,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     wb_data,
    output logic [REG_ADDR_W-1:0] wb_dest_reg,
    output logic                  wb_reg_write,
    output logic                  wb_err
);

    localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_t            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  req_reg, req_next;
    logic                  we_reg, we_next;
    logic [DATA_W-1:0]     addr_reg, addr_next;
    logic [DATA_W-1:0]     wdata_reg, wdata_next;
    logic [REG_ADDR_W-1:0] dest_reg, dest_next;
    logic                  rw_reg, rw_next;
    wb_rec_t               wb_reg, wb_next;

    logic accept;
    logic is_mem;
    logic timed_out;

    assign accept    = valid_exmm && (state_reg == MS_IDLE);
    assign is_mem    = load_exmm || store_exmm;
    assign timed_out = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_next   = req_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        dest_next  = dest_reg;
        rw_next    = rw_reg;
        wb_next    = '0;

        case (state_reg)
            MS_IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_next = make_wb(alu_result_exmm, dest_reg_exmm,
                                          reg_write_valid_exmm, 1'b0);
                    end else if (alu_result_exmm[0]) begin
                        wb_next = make_wb(alu_result_exmm, dest_reg_exmm, 1'b0, 1'b1);
                    end else begin
                        state_next = MS_REQ;
                        cnt_next   = '0;
                        req_next   = 1'b1;
                        we_next    = store_exmm;
                        addr_next  = alu_result_exmm;
                        wdata_next = store_data_exmm;
                        dest_next  = dest_reg_exmm;
                        rw_next    = reg_write_valid_exmm;
                    end
                end
            end

            // Completion is tested before the timeout so a late-but-final
            // handshake still retires cleanly.
            MS_REQ: begin
                if (dmem.gnt && we_reg) begin
                    state_next = MS_IDLE;
                    req_next   = 1'b0;
                    wb_next    = make_wb(addr_reg, dest_reg, 1'b0, 1'b0);
                end else if (dmem.gnt && dmem.rvalid) begin
                    state_next = MS_IDLE;
                    req_next   = 1'b0;
                    wb_next    = make_wb(dmem.rdata, dest_reg, rw_reg, 1'b0);
                end else if (timed_out) begin
                    state_next = MS_IDLE;
                    req_next   = 1'b0;
                    wb_next    = make_wb(addr_reg, dest_reg, 1'b0, 1'b1);
                end else if (dmem.gnt) begin
                    state_next = MS_WAIT;
                    req_next   = 1'b0;
                    cnt_next   = cnt_reg + CNT_ONE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            MS_WAIT: begin
                if (dmem.rvalid) begin
                    state_next = MS_IDLE;
                    wb_next    = make_wb(dmem.rdata, dest_reg, rw_reg, 1'b0);
                end else if (timed_out) begin
                    state_next = MS_IDLE;
                    wb_next    = make_wb(addr_reg, dest_reg, 1'b0, 1'b1);
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            default: begin
                state_next = MS_IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= MS_IDLE;
            cnt_reg   <= '0;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            dest_reg  <= '0;
            rw_reg    <= 1'b0;
            wb_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            req_reg   <= req_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            dest_reg  <= dest_next;
            rw_reg    <= rw_next;
            wb_reg    <= wb_next;
        end
    end

    assign dmem.req   = req_reg;
    assign dmem.we    = we_reg;
    assign dmem.addr  = addr_reg;
    assign dmem.wdata = wdata_reg;

    assign mem_stall    = (state_reg != MS_IDLE);
    assign wb_valid     = wb_reg.valid;
    assign wb_data      = wb_reg.data;
    assign wb_dest_reg  = wb_reg.dest;
    assign wb_reg_write = wb_reg.reg_write;
    assign wb_err       = wb_reg.err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected wb records (with
// their due cycle) into a scoreboard; a negedge monitor pops and compares.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_exmm = 1'b0;
    logic [15:0] alu_result_exmm = '0;
    logic [15:0] store_data_exmm = '0;
    logic        load_exmm = 1'b0;
    logic        store_exmm = 1'b0;
    logic [2:0]  dest_reg_exmm = '0;
    logic        reg_write_valid_exmm = 1'b0;
    logic        mem_stall;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_dest_reg;
    logic        wb_reg_write;
    logic        wb_err;

    mem_stage_if dmem ();

    mem_stage #(.MEM_TIMEOUT(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .valid_exmm           (valid_exmm),
        .alu_result_exmm      (alu_result_exmm),
        .store_data_exmm      (store_data_exmm),
        .load_exmm            (load_exmm),
        .store_exmm           (store_exmm),
        .dest_reg_exmm        (dest_reg_exmm),
        .reg_write_valid_exmm (reg_write_valid_exmm),
        .dmem                 (dmem),
        .mem_stall            (mem_stall),
        .wb_valid             (wb_valid),
        .wb_data              (wb_data),
        .wb_dest_reg          (wb_dest_reg),
        .wb_reg_write         (wb_reg_write),
        .wb_err               (wb_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  dest;
        logic        rw;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected record becomes visible 'lat' cycles after the accepting edge's predecessor.
    task automatic push(input logic [15:0] d, input logic [2:0] dest,
                        input logic rw, input logic err, input int lat);
        exp_t e;
        e.data = d; e.dest = dest; e.rw = rw; e.err = err; e.due = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [15:0] alu,
                         input logic [15:0] sd, input logic [2:0] dest, input logic rw);
        valid_exmm = 1'b1;
        load_exmm = ld;
        store_exmm = st;
        alu_result_exmm = alu;
        store_data_exmm = sd;
        dest_reg_exmm = dest;
        reg_write_valid_exmm = rw;
    endtask

    task automatic idle();
        valid_exmm = 1'b0;
        load_exmm = 1'b0;
        store_exmm = 1'b0;
    endtask

    always @(negedge clk) begin
        if (wb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", {16'h0, wb_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("wb tx: cycle=%0d data=%h dest=%0d rw=%0b err=%0b", cyc,
                         wb_data, wb_dest_reg, wb_reg_write, wb_err);
                chk("wb_cycle", cyc, e.due);
                chk("wb_data", {16'h0, wb_data}, {16'h0, e.data});
                chk("wb_dest", {29'h0, wb_dest_reg}, {29'h0, e.dest});
                chk("wb_reg_write", {31'h0, wb_reg_write}, {31'h0, e.rw});
                chk("wb_err", {31'h0, wb_err}, {31'h0, e.err});
            end
        end else begin
            chk("wb_idle_zero", {11'h0, wb_data, wb_dest_reg, wb_reg_write, wb_err}, 32'h0);
        end
        if (sb.size() > 0 && cyc > sb[0].due) begin
            chk("wb_missing", 32'(cyc), 32'(sb[0].due));
            void'(sb.pop_front());
        end
    end

    initial begin
        dmem.gnt = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_req", {31'h0, dmem.req}, 32'h0);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_addr", {16'h0, dmem.addr}, 32'h0);
        rst = 1'b1;
        tick();

        // Three back-to-back pass-through ops
        issue(1'b0, 1'b0, 16'h0011, 16'h0, 3'd1, 1'b1); push(16'h0011, 3'd1, 1'b1, 1'b0, 1);
        tick(); chk("pt_stall0", {31'h0, mem_stall}, 32'h0);
        issue(1'b0, 1'b0, 16'h0022, 16'h0, 3'd2, 1'b1); push(16'h0022, 3'd2, 1'b1, 1'b0, 1);
        tick(); chk("pt_stall1", {31'h0, mem_stall}, 32'h0);
        issue(1'b0, 1'b0, 16'h0033, 16'h0, 3'd3, 1'b0); push(16'h0033, 3'd3, 1'b0, 1'b0, 1);
        tick(); chk("pt_stall2", {31'h0, mem_stall}, 32'h0);
        idle();
        tick(); tick();

        // Zero-wait load
        issue(1'b1, 1'b0, 16'h0040, 16'h0, 3'd2, 1'b1); push(16'hBEEF, 3'd2, 1'b1, 1'b0, 2);
        tick(); idle();
        chk("zw_stall", {31'h0, mem_stall}, 32'h1);
        chk("zw_req", {31'h0, dmem.req}, 32'h1);
        chk("zw_we", {31'h0, dmem.we}, 32'h0);
        chk("zw_addr", {16'h0, dmem.addr}, 32'h0040);
        dmem.gnt = 1'b1; dmem.rvalid = 1'b1; dmem.rdata = 16'hBEEF;
        tick();
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
        chk("zw_stall_end", {31'h0, mem_stall}, 32'h0);
        chk("zw_req_end", {31'h0, dmem.req}, 32'h0);
        tick();

        // Store with grant in the third request cycle
        issue(1'b0, 1'b1, 16'h0100, 16'h1234, 3'd3, 1'b1); push(16'h0100, 3'd3, 1'b0, 1'b0, 4);
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            chk("st_req", {31'h0, dmem.req}, 32'h1);
            chk("st_we", {31'h0, dmem.we}, 32'h1);
            chk("st_addr", {16'h0, dmem.addr}, 32'h0100);
            chk("st_wdata", {16'h0, dmem.wdata}, 32'h1234);
            chk("st_stall", {31'h0, mem_stall}, 32'h1);
            if (i == 2) dmem.gnt = 1'b1;
            tick();
        end
        dmem.gnt = 1'b0;
        chk("st_req_end", {31'h0, dmem.req}, 32'h0);
        chk("st_stall_end", {31'h0, mem_stall}, 32'h0);
        tick();

        // Misaligned load
        issue(1'b1, 1'b0, 16'h0041, 16'h0, 3'd4, 1'b1); push(16'h0041, 3'd4, 1'b0, 1'b1, 1);
        tick(); idle();
        chk("mis_req", {31'h0, dmem.req}, 32'h0);
        chk("mis_stall", {31'h0, mem_stall}, 32'h0);
        tick();

        // Timeout: granted, rvalid never arrives in time; late rvalid ignored
        issue(1'b1, 1'b0, 16'h0080, 16'h0, 3'd5, 1'b1); push(16'h0080, 3'd5, 1'b0, 1'b1, 5);
        tick(); idle();
        chk("to_req", {31'h0, dmem.req}, 32'h1);
        dmem.gnt = 1'b1;
        tick();
        dmem.gnt = 1'b0;
        chk("to_req_wait", {31'h0, dmem.req}, 32'h0);
        chk("to_stall_wait", {31'h0, mem_stall}, 32'h1);
        tick(); tick();
        chk("to_stall_last", {31'h0, mem_stall}, 32'h1);
        tick();
        chk("to_stall_end", {31'h0, mem_stall}, 32'h0);
        dmem.rvalid = 1'b1; dmem.rdata = 16'hDEAD;
        tick();
        dmem.rvalid = 1'b0;
        tick(); tick();

        // Completion on the final timeout cycle wins
        issue(1'b1, 1'b0, 16'h00A0, 16'h0, 3'd6, 1'b1); push(16'h5A5A, 3'd6, 1'b1, 1'b0, 5);
        tick(); idle();
        dmem.gnt = 1'b1;
        tick();
        dmem.gnt = 1'b0;
        tick(); tick();
        dmem.rvalid = 1'b1; dmem.rdata = 16'h5A5A;
        tick();
        dmem.rvalid = 1'b0;
        tick(); tick();

        // Reset during WAIT drops the access; a following load completes
        issue(1'b1, 1'b0, 16'h00C0, 16'h0, 3'd7, 1'b1);
        tick(); idle();
        dmem.gnt = 1'b1;
        tick();
        dmem.gnt = 1'b0;
        chk("rw_stall_wait", {31'h0, mem_stall}, 32'h1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rw_req", {31'h0, dmem.req}, 32'h0);
        chk("rw_stall", {31'h0, mem_stall}, 32'h0);
        chk("rw_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rw_addr", {16'h0, dmem.addr}, 32'h0);
        tick();
        issue(1'b1, 1'b0, 16'h00C2, 16'h0, 3'd1, 1'b1); push(16'h1357, 3'd1, 1'b1, 1'b0, 2);
        tick(); idle();
        chk("rw_new_req", {31'h0, dmem.req}, 32'h1);
        dmem.gnt = 1'b1; dmem.rvalid = 1'b1; dmem.rdata = 16'h1357;
        tick();
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
        repeat (4) tick();

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
